// File: rtl/module_display_pkg.sv
// module_display_pkg: shared state type, digit count and cyclic digit search for the display scanner
package module_display_pkg;

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;

    localparam int NUM_DIGITS = 4;

    // First enabled index strictly after sel in cyclic order, falling back to sel itself last
    function automatic logic [1:0] next_enabled(input logic [1:0] sel, input logic [NUM_DIGITS-1:0] mask);
        logic [1:0] r;
        logic [1:0] idx;
        r = sel;
        for (int k = NUM_DIGITS; k >= 1; k--) begin
            idx = sel + 2'(k);
            if (mask[idx]) r = idx;
        end
        return r;
    endfunction

endpackage

// File: rtl/module_display_scan_if.sv
// module_display_scan_if: digit mask in, mux select / anode drive / slot pulse out
interface module_display_scan_if;
    import module_display_pkg::*;

    logic [NUM_DIGITS-1:0] digit_en;
    logic [1:0]            sel;
    logic [NUM_DIGITS-1:0] an;
    logic                  slot_tick;

    modport master (output digit_en, input sel, an, slot_tick);
    modport slave  (input digit_en, output sel, an, slot_tick);

endinterface

// File: rtl/module_prescaler.sv
// module_prescaler: free-running 0..DIV-1 counter with a tick on the last count and a hold-at-zero clear
module module_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    assign tick = cnt_q == PW'(DIV - 1);

    // Wrap on the last count, pin to zero while cleared
    always_comb begin
        cnt_d = (clear || tick) ? '0 : cnt_q + PW'(1);
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/module_display_scan.sv
// module_display_scan: blanked, time-multiplexed scan of a 4-digit common-anode display
module module_display_scan
    import module_display_pkg::*;
#(
    parameter int CLK_HZ       = 27_000_000,
    parameter int DIGIT_HZ     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input logic                  clk,
    input logic                  rst,
    module_display_scan_if.slave bus
);

    localparam int DIV = CLK_HZ / DIGIT_HZ;
    localparam int BW  = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;

    generate
        if (DIV < BLANK_CYCLES + 2 || BLANK_CYCLES < 1) begin : g_bad_params
            $error("module_display_scan: DIV must be at least BLANK_CYCLES + 2 and BLANK_CYCLES at least 1");
        end
    endgenerate

    scan_state_t           state_q, state_d;
    logic [1:0]            sel_q, sel_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  tick_q, tick_d;
    logic [BW-1:0]         blank_q, blank_d;
    logic                  presc_tick;

    module_prescaler #(.DIV(DIV)) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == IDLE),
        .tick  (presc_tick)
    );

    // Next state, select, blank count and slot pulse; anodes follow the next state so they stay registered
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        blank_d = blank_q;
        tick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.digit_en) begin
                    state_d = BLANK;
                    sel_d   = next_enabled(2'd3, bus.digit_en);
                    blank_d = '0;
                end
            end
            BLANK, SHOW: begin
                if (~|bus.digit_en) begin
                    state_d = IDLE;
                end else if (presc_tick) begin
                    state_d = BLANK;
                    sel_d   = next_enabled(sel_q, bus.digit_en);
                    blank_d = '0;
                    tick_d  = 1'b1;
                end else if (state_q == BLANK) begin
                    if (blank_q == BW'(BLANK_CYCLES - 1)) state_d = SHOW;
                    else                                  blank_d = blank_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        an_d = (state_d == SHOW && bus.digit_en[sel_d]) ? ~(4'b0001 << sel_d) : 4'b1111;
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'b00;
            an_q    <= 4'b1111;
            tick_q  <= 1'b0;
            blank_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
            blank_q <= blank_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.an        = an_q;
    assign bus.slot_tick = tick_q;

endmodule

// File: tb/tb_module_display_scan.sv
// tb_module_display_scan: directed scan sequences with hand-computed anode/select/tick values
module tb_module_display_scan;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    module_display_scan_if bus ();

    module_display_scan #(
        .CLK_HZ       (100),
        .DIGIT_HZ     (10),
        .BLANK_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] an, input logic [1:0] sel, input logic tick);
        chk({tag, ".an"}, bus.an, an);
        chk({tag, ".sel"}, {2'b00, bus.sel}, {2'b00, sel});
        chk({tag, ".tick"}, {3'b000, bus.slot_tick}, {3'b000, tick});
    endtask

    initial begin
        rst          = 1'b1;
        bus.digit_en = 4'b1111;
        #22;
        chk_all("reset", 4'b1111, 2'd0, 1'b0);
        rst = 1'b0;
        chk_all("release", 4'b1111, 2'd0, 1'b0);
        // full scan: IDLE exit, two blank cycles, eight lit
        step(1);  chk_all("full.e1", 4'b1111, 2'd0, 1'b0);
        step(1);  chk_all("full.e2", 4'b1111, 2'd0, 1'b0);
        step(1);  chk_all("full.e3", 4'b1110, 2'd0, 1'b0);
        step(7);  chk_all("full.e10", 4'b1110, 2'd0, 1'b0);
        step(1);  chk_all("full.e11", 4'b1111, 2'd1, 1'b1);
        step(1);  chk_all("full.e12", 4'b1111, 2'd1, 1'b0);
        step(1);  chk_all("full.e13", 4'b1101, 2'd1, 1'b0);
        step(8);  chk_all("full.e21", 4'b1111, 2'd2, 1'b1);
        step(10); chk_all("full.e31", 4'b1111, 2'd3, 1'b1);
        step(10); chk_all("full.e41", 4'b1111, 2'd0, 1'b1);
        // sparse mask 0101
        bus.digit_en = 4'b0101;
        step(2);  chk_all("sparse.e43", 4'b1110, 2'd0, 1'b0);
        step(8);  chk_all("sparse.e51", 4'b1111, 2'd2, 1'b1);
        step(2);  chk_all("sparse.e53", 4'b1011, 2'd2, 1'b0);
        step(8);  chk_all("sparse.e61", 4'b1111, 2'd0, 1'b1);
        step(2);  chk_all("sparse.e63", 4'b1110, 2'd0, 1'b0);
        // single digit 0010, current digit 0 drops out mid-SHOW
        bus.digit_en = 4'b0010;
        step(1);  chk_all("single.e64", 4'b1111, 2'd0, 1'b0);
        step(7);  chk_all("single.e71", 4'b1111, 2'd1, 1'b1);
        step(2);  chk_all("single.e73", 4'b1101, 2'd1, 1'b0);
        step(7);  chk_all("single.e80", 4'b1101, 2'd1, 1'b0);
        step(1);  chk_all("single.e81", 4'b1111, 2'd1, 1'b1);
        step(3);  chk_all("single.e84", 4'b1101, 2'd1, 1'b0);
        // mask to zero mid-SHOW, then 1000
        bus.digit_en = 4'b0000;
        step(1);  chk_all("zero.e85", 4'b1111, 2'd1, 1'b0);
        step(1);  chk_all("zero.e86", 4'b1111, 2'd1, 1'b0);
        bus.digit_en = 4'b1000;
        step(1);  chk_all("d3.e87", 4'b1111, 2'd3, 1'b0);
        step(1);  chk_all("d3.e88", 4'b1111, 2'd3, 1'b0);
        step(1);  chk_all("d3.e89", 4'b0111, 2'd3, 1'b0);
        // current digit disabled while lit
        bus.digit_en = 4'b1111;
        step(8);  chk_all("dis.e97", 4'b1111, 2'd0, 1'b1);
        step(20); chk_all("dis.e117", 4'b1111, 2'd2, 1'b1);
        step(2);  chk_all("dis.e119", 4'b1011, 2'd2, 1'b0);
        bus.digit_en = 4'b1011;
        step(1);  chk_all("dis.e120", 4'b1111, 2'd2, 1'b0);
        step(6);  chk_all("dis.e126", 4'b1111, 2'd2, 1'b0);
        step(1);  chk_all("dis.e127", 4'b1111, 2'd3, 1'b1);
        step(2);  chk_all("dis.e129", 4'b0111, 2'd3, 1'b0);
        // asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk_all("arst", 4'b1111, 2'd0, 1'b0);
        step(1);  chk_all("arst.hold", 4'b1111, 2'd0, 1'b0);
        // release with an empty mask stays idle
        bus.digit_en = 4'b0000;
        rst          = 1'b0;
        step(12); chk_all("idle.empty", 4'b1111, 2'd0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
